volume_ramp_ctrl: RTL and testbench

//   Parametrised volume controller: converts held inc/dec buttons into a

---
 rtl/vol_pkg.sv | 17 +
 rtl/volume_ramp_ctrl_if.sv | 24 ++
 rtl/volume_ramp_ctrl_key_autorepeat.sv | 77 +++++++
 rtl/volume_ramp_ctrl.sv | 90 +++++++++
 tb/tb_volume_ramp_ctrl.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/vol_pkg.sv
// Shared types and default constants for the volume ramp controller.
package vol_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        REPEAT
    } rpt_state_e;

    localparam int unsigned DEF_LEVELS     = 16;
    localparam int unsigned DEF_MID        = 32'h0000_8000;
    localparam int unsigned DEF_STEP       = 2000;
    localparam int unsigned DEF_RAMP_STEP  = 500;
    localparam int unsigned DEF_REPEAT_DLY = 25_000_000;
    localparam int unsigned DEF_REPEAT_PER = 10_000_000;

endpackage

// File: rtl/volume_ramp_ctrl_if.sv
// Keypad-side controls and audio-side amplitude outputs of the volume controller.
interface volume_ramp_ctrl_if #(
    parameter int LVL_W = 4,
    parameter int AMP_W = 16
);
    logic             inc;
    logic             dec;
    logic             mute_tgl;
    logic             ramp_tick;
    logic [LVL_W-1:0] level;
    logic [AMP_W-1:0] amp;
    logic             muted;
    logic             ramping;

    modport master (
        output inc, dec, mute_tgl, ramp_tick,
        input  level, amp, muted, ramping
    );

    modport slave (
        input  inc, dec, mute_tgl, ramp_tick,
        output level, amp, muted, ramping
    );
endinterface

// File: rtl/volume_ramp_ctrl_key_autorepeat.sv
// Held-button auto-repeat: one step on press, then after REPEAT_DLY cycles,
// then every REPEAT_PER cycles while the button stays down.
module key_autorepeat
    import vol_pkg::*;
#(
    parameter int unsigned REPEAT_DLY = DEF_REPEAT_DLY,
    parameter int unsigned REPEAT_PER = DEF_REPEAT_PER
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    input  logic enable_i,
    output logic step_o
);
    localparam int unsigned CNT_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
    localparam int          CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] DLY_C = CNT_W'(REPEAT_DLY);
    localparam logic [CNT_W-1:0] PER_C = CNT_W'(REPEAT_PER);

    rpt_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register update order-independent.
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        // NOTE: defaults first so no path through this block can infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!enable_i || !btn_i) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = HOLD;
                    cnt_d   = CNT_W'(1);
                end
                HOLD: begin
                    if (cnt_q == DLY_C) begin
                        state_d = REPEAT;
                        cnt_d   = CNT_W'(1);
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                REPEAT: begin
                    cnt_d = (cnt_q == PER_C) ? CNT_W'(1) : cnt_q + CNT_W'(1);
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        step_o = 1'b0;
        if (enable_i && btn_i) begin
            unique case (state_q)
                IDLE:    step_o = 1'b1;
                HOLD:    step_o = (cnt_q == DLY_C);
                REPEAT:  step_o = (cnt_q == PER_C);
                default: step_o = 1'b0;
            endcase
        end
    end
endmodule

// File: rtl/volume_ramp_ctrl.sv
// Saturating volume level with key auto-repeat and mute, driving an
// offset-binary amplitude that slews toward its target to avoid clicks.
module volume_ramp_ctrl
    import vol_pkg::*;
#(
    parameter int unsigned        LEVELS     = DEF_LEVELS,
    parameter int unsigned        AMP_W      = 16,
    parameter logic [AMP_W-1:0]   MID        = AMP_W'(DEF_MID),
    parameter int unsigned        STEP       = DEF_STEP,
    parameter int unsigned        RAMP_STEP  = DEF_RAMP_STEP,
    parameter int unsigned        REPEAT_DLY = DEF_REPEAT_DLY,
    parameter int unsigned        REPEAT_PER = DEF_REPEAT_PER
) (
    input logic                clk,
    input logic                rst,
    volume_ramp_ctrl_if.slave  bus
);
    localparam int              LVL_W   = $clog2(LEVELS);
    localparam logic [LVL_W-1:0] MAX_LVL = LVL_W'(LEVELS - 1);
    localparam logic [AMP_W:0]   RAMP_C  = (AMP_W + 1)'(RAMP_STEP);
    localparam longint unsigned  AMP_TOP = longint'(MID) + longint'(LEVELS - 1) * longint'(STEP);

    if (AMP_TOP >= (64'd1 << AMP_W) || REPEAT_PER < 1 || RAMP_STEP < 1) begin : g_bad_cfg
        $error("volume_ramp_ctrl: amplitude range overflows AMP_W or zero repeat/ramp step");
    end

    logic [LVL_W-1:0] level_q, level_d;
    logic [AMP_W-1:0] amp_q, amp_d;
    logic             muted_q, muted_d;
    logic             keys_ok, inc_step, dec_step;
    logic [AMP_W:0]   target_w, amp_x;
    logic [AMP_W-1:0] target;

    // Pressing both buttons cancels both; each FSM restarts from IDLE afterwards.
    assign keys_ok = !(bus.inc && bus.dec);

    key_autorepeat #(.REPEAT_DLY(REPEAT_DLY), .REPEAT_PER(REPEAT_PER)) u_inc_rpt (
        .clk(clk), .rst(rst), .btn_i(bus.inc), .enable_i(keys_ok), .step_o(inc_step)
    );

    key_autorepeat #(.REPEAT_DLY(REPEAT_DLY), .REPEAT_PER(REPEAT_PER)) u_dec_rpt (
        .clk(clk), .rst(rst), .btn_i(bus.dec), .enable_i(keys_ok), .step_o(dec_step)
    );

    always_comb begin
        target_w = muted_q ? {1'b0, MID}
                           : {1'b0, MID} + (AMP_W + 1)'(level_q) * (AMP_W + 1)'(STEP);
        target   = target_w[AMP_W-1:0];
    end

    always_comb begin
        level_d = level_q;
        if (inc_step && level_q != MAX_LVL) begin
            level_d = level_q + LVL_W'(1);
        end else if (dec_step && level_q != '0) begin
            level_d = level_q - LVL_W'(1);
        end
        muted_d = muted_q ^ bus.mute_tgl;
    end

    // Slew limited to RAMP_C per tick; the AMP_W+1 compare avoids wrap near full scale.
    always_comb begin
        amp_x = {1'b0, amp_q};
        amp_d = amp_q;
        if (bus.ramp_tick) begin
            if (amp_x < target_w) begin
                amp_d = ((target_w - amp_x) <= RAMP_C) ? target : amp_q + RAMP_C[AMP_W-1:0];
            end else if (amp_x > target_w) begin
                amp_d = ((amp_x - target_w) <= RAMP_C) ? target : amp_q - RAMP_C[AMP_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            level_q <= '0;
            amp_q   <= MID;
            muted_q <= 1'b0;
        end else begin
            level_q <= level_d;
            amp_q   <= amp_d;
            muted_q <= muted_d;
        end
    end

    assign bus.level   = level_q;
    assign bus.amp     = amp_q;
    assign bus.muted   = muted_q;
    assign bus.ramping = (amp_q != target);
endmodule

// File: tb/tb_volume_ramp_ctrl.sv
// Self-checking bench for volume_ramp_ctrl with short auto-repeat timing and
// an arithmetic reference model of level, mute and amplitude slewing.
module tb_volume_ramp_ctrl;
    localparam int LEVELS = 16;
    localparam int AMP_W  = 16;
    localparam int LVL_W  = 4;
    localparam int MIDV   = 32768;
    localparam int STEP   = 2000;
    localparam int RAMP   = 500;
    localparam int DLY    = 8;
    localparam int PER    = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests_run    = 0;
    int   tests_failed = 0;

    int m_level = 0;
    int m_amp   = MIDV;
    bit m_muted = 1'b0;
    int hold_inc = 0;
    int hold_dec = 0;

    always #5 clk = ~clk;

    volume_ramp_ctrl_if #(.LVL_W(LVL_W), .AMP_W(AMP_W)) bus ();

    volume_ramp_ctrl #(
        .LEVELS(LEVELS), .AMP_W(AMP_W), .MID(16'h8000), .STEP(STEP),
        .RAMP_STEP(RAMP), .REPEAT_DLY(DLY), .REPEAT_PER(PER)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    function automatic int m_target();
        return m_muted ? MIDV : MIDV + m_level * STEP;
    endfunction

    function automatic bit m_ramping();
        return m_amp != m_target();
    endfunction

    // A held button steps on its first cycle, after DLY more cycles, then every PER.
    function automatic bit is_step(int h);
        return (h == 1) || (h >= DLY + 1 && ((h - 1 - DLY) % PER) == 0);
    endfunction

    task automatic tick();
        int t;
        @(posedge clk);
        if (rst) begin
            m_level = 0; m_amp = MIDV; m_muted = 1'b0; hold_inc = 0; hold_dec = 0;
        end else begin
            t = m_target();
            if (bus.ramp_tick) begin
                if (m_amp < t)      m_amp = (t - m_amp <= RAMP) ? t : m_amp + RAMP;
                else if (m_amp > t) m_amp = (m_amp - t <= RAMP) ? t : m_amp - RAMP;
            end
            if (bus.inc && bus.dec) begin
                hold_inc = 0; hold_dec = 0;
            end else begin
                hold_inc = bus.inc ? hold_inc + 1 : 0;
                hold_dec = bus.dec ? hold_dec + 1 : 0;
                if (bus.inc && is_step(hold_inc) && m_level < LEVELS - 1) m_level++;
                if (bus.dec && is_step(hold_dec) && m_level > 0) m_level--;
            end
            if (bus.mute_tgl) m_muted = !m_muted;
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; bus.inc = 1'b0; bus.dec = 1'b0; bus.mute_tgl = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.inc = 1'b0; bus.dec = 1'b0; bus.mute_tgl = 1'b0; bus.ramp_tick = 1'b1;
        repeat (3) tick();
        tests_run++;
        if (bus.level !== 4'd0) begin
            tests_failed++; $display("FAIL reset_level: got %0d expected 0", bus.level);
        end
        tests_run++;
        if (bus.amp !== 16'h8000) begin
            tests_failed++; $display("FAIL reset_amp: got %h expected 8000", bus.amp);
        end
        tests_run++;
        if (bus.muted !== 1'b0 || bus.ramping !== 1'b0) begin
            tests_failed++; $display("FAIL reset_flags: got muted=%b ramping=%b expected 0 0", bus.muted, bus.ramping);
        end
        rst = 1'b0;
    endtask

    task automatic test_single_inc();
        logic [15:0] exp_amp [4];
        exp_amp[0] = 16'h81F4; exp_amp[1] = 16'h83E8; exp_amp[2] = 16'h85DC; exp_amp[3] = 16'h87D0;
        bus.inc = 1'b1;
        tick();
        bus.inc = 1'b0;
        tests_run++;
        if (bus.level !== 4'd1 || bus.amp !== 16'h8000 || bus.ramping !== 1'b1) begin
            tests_failed++;
            $display("FAIL single_inc_first: got level=%0d amp=%h ramping=%b expected 1 8000 1", bus.level, bus.amp, bus.ramping);
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            tests_run++;
            if (bus.amp !== exp_amp[k] || bus.ramping !== (k < 3)) begin
                tests_failed++;
                $display("FAIL single_inc_ramp%0d: got amp=%h ramping=%b expected %h %b", k, bus.amp, bus.ramping, exp_amp[k], (k < 3));
            end
        end
    endtask

    task automatic test_inc_hold();
        int exp_lvl;
        do_reset();
        bus.inc = 1'b1;
        for (int n = 1; n <= 80; n++) begin
            tick();
            exp_lvl = (n < 9) ? 1 : 2 + (n - 9) / PER;
            if (exp_lvl > LEVELS - 1) exp_lvl = LEVELS - 1;
            tests_run++;
            if (bus.level !== LVL_W'(exp_lvl) || bus.amp !== AMP_W'(m_amp)) begin
                tests_failed++;
                $display("FAIL inc_hold_edge%0d: got level=%0d amp=%h expected %0d %h", n, bus.level, bus.amp, exp_lvl, AMP_W'(m_amp));
            end
        end
        bus.inc = 1'b0;
        for (int i = 0; i < 100 && m_ramping(); i++) tick();
        tick();
        tests_run++;
        if (bus.level !== 4'd15 || bus.amp !== 16'hF530 || bus.ramping !== 1'b0) begin
            tests_failed++;
            $display("FAIL inc_hold_settle: got level=%0d amp=%h ramping=%b expected 15 f530 0", bus.level, bus.amp, bus.ramping);
        end
    endtask

    task automatic test_dec_floor();
        do_reset();
        bus.dec = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            tick();
            tests_run++;
            if (bus.level !== 4'd0 || bus.amp !== 16'h8000) begin
                tests_failed++;
                $display("FAIL dec_floor_edge%0d: got level=%0d amp=%h expected 0 8000", n, bus.level, bus.amp);
            end
        end
        bus.dec = 1'b0;
    endtask

    task automatic test_mute();
        int n;
        do_reset();
        repeat (5) begin
            bus.inc = 1'b1; tick();
            bus.inc = 1'b0; tick();
        end
        repeat (40) tick();
        tests_run++;
        if (bus.level !== 4'd5 || bus.amp !== 16'hA710) begin
            tests_failed++; $display("FAIL mute_setup: got level=%0d amp=%h expected 5 a710", bus.level, bus.amp);
        end
        bus.mute_tgl = 1'b1; tick(); bus.mute_tgl = 1'b0;
        tests_run++;
        if (bus.muted !== 1'b1 || bus.ramping !== 1'b1 || bus.amp !== 16'hA710) begin
            tests_failed++;
            $display("FAIL mute_on: got muted=%b ramping=%b amp=%h expected 1 1 a710", bus.muted, bus.ramping, bus.amp);
        end
        n = 0;
        while (bus.amp !== 16'h8000 && n < 40) begin tick(); n++; end
        tests_run++;
        if (n !== 20 || bus.ramping !== 1'b0 || bus.level !== 4'd5) begin
            tests_failed++;
            $display("FAIL mute_ramp_down: got ticks=%0d ramping=%b level=%0d expected 20 0 5", n, bus.ramping, bus.level);
        end
        bus.mute_tgl = 1'b1; tick(); bus.mute_tgl = 1'b0;
        n = 0;
        while (bus.amp !== 16'hA710 && n < 40) begin tick(); n++; end
        tests_run++;
        if (n !== 20 || bus.muted !== 1'b0 || bus.ramping !== 1'b0) begin
            tests_failed++;
            $display("FAIL mute_ramp_up: got ticks=%0d muted=%b ramping=%b expected 20 0 0", n, bus.muted, bus.ramping);
        end
    endtask

    task automatic test_both_and_reset();
        bus.inc = 1'b1; bus.dec = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            tick();
            tests_run++;
            if (bus.level !== 4'd5) begin
                tests_failed++; $display("FAIL both_held_edge%0d: got level=%0d expected 5", n, bus.level);
            end
        end
        bus.dec = 1'b0;
        tick();
        bus.inc = 1'b0;
        tests_run++;
        if (bus.level !== 4'd6) begin
            tests_failed++; $display("FAIL both_release: got level=%0d expected 6", bus.level);
        end
        tick();
        tests_run++;
        if (bus.ramping !== 1'b1 || bus.amp !== 16'hA904) begin
            tests_failed++; $display("FAIL mid_ramp: got amp=%h ramping=%b expected a904 1", bus.amp, bus.ramping);
        end
        rst = 1'b1; tick(); rst = 1'b0;
        tests_run++;
        if (bus.amp !== 16'h8000 || bus.level !== 4'd0 || bus.ramping !== 1'b0 || bus.muted !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid_ramp: got amp=%h level=%0d ramping=%b muted=%b expected 8000 0 0 0", bus.amp, bus.level, bus.ramping, bus.muted);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(15) == 0) bus.inc = ~bus.inc;
            if ($urandom_range(15) == 0) bus.dec = ~bus.dec;
            bus.mute_tgl = ($urandom_range(63) == 0);
            rst = ($urandom_range(999) == 0);
            tick();
            tests_run++;
            if ({bus.level, bus.amp, bus.muted, bus.ramping} !==
                {LVL_W'(m_level), AMP_W'(m_amp), m_muted, m_ramping()}) begin
                tests_failed++;
                $display("FAIL random_cycle%0d: got level=%0d amp=%h muted=%b ramping=%b expected %0d %h %b %b",
                         c, bus.level, bus.amp, bus.muted, bus.ramping, m_level, AMP_W'(m_amp), m_muted, m_ramping());
            end
        end
        rst = 1'b0; bus.inc = 1'b0; bus.dec = 1'b0; bus.mute_tgl = 1'b0;
    endtask

    initial begin
        bus.inc = 1'b0; bus.dec = 1'b0; bus.mute_tgl = 1'b0; bus.ramp_tick = 1'b1;
        test_reset();
        test_single_inc();
        test_inc_hold();
        test_dec_floor();
        test_mute();
        test_both_and_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
